// File: rtl/prf_multiport.sv
// ============================================================================
// Module   : prf_multiport
// Brief    : Multi-port physical register file with per-register busy
//            scoreboard, write-first read bypass and write-collision flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prf_multiport #(
    parameter int PR_SIZE   = 6,
    parameter int PR_ARRAY  = 64,
    parameter int DATA_W    = 32,
    parameter int NUM_RD    = 4,
    parameter int NUM_WR    = 2,
    parameter int NUM_ALLOC = 2
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [NUM_RD-1:0]           rd_en,
    input  logic [NUM_RD*PR_SIZE-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]    rd_data,
    output logic [NUM_RD-1:0]           rd_ready,
    input  logic [NUM_WR-1:0]           wr_en,
    input  logic [NUM_WR*PR_SIZE-1:0]   wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]    wr_data,
    input  logic [NUM_ALLOC-1:0]        alloc_en,
    input  logic [NUM_ALLOC*PR_SIZE-1:0] alloc_addr,
    input  logic                        flush,
    output logic                        wr_collide
);

    localparam logic [PR_SIZE:0] c_pr_array = PR_ARRAY[PR_SIZE:0];

    logic [DATA_W-1:0]   r_mem [PR_ARRAY];
    logic [PR_ARRAY-1:0] r_busy;

    logic [NUM_WR-1:0]    w_wr_ok;
    logic [NUM_ALLOC-1:0] w_al_ok;
    logic [PR_ARRAY-1:0]  w_busy_nxt;
    logic                 w_collide;
    logic [DATA_W-1:0]    w_rd_data  [NUM_RD];
    logic [NUM_RD-1:0]    w_rd_ready;

    // Register 0 and out-of-range addresses never hold state.
    function automatic logic addr_ok(input logic [PR_SIZE-1:0] a);
        return (a != '0) && ({1'b0, a} < c_pr_array);
    endfunction

    always_comb begin
        w_wr_ok = '0;
        w_al_ok = '0;
        for (int w = 0; w < NUM_WR; w++)
            w_wr_ok[w] = wr_en[w] && addr_ok(wr_addr[w*PR_SIZE +: PR_SIZE]);
        for (int a = 0; a < NUM_ALLOC; a++)
            w_al_ok[a] = alloc_en[a] && addr_ok(alloc_addr[a*PR_SIZE +: PR_SIZE]);
    end

    // Priority: flush > alloc set > write clear.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int w = 0; w < NUM_WR; w++)
            if (w_wr_ok[w]) w_busy_nxt[wr_addr[w*PR_SIZE +: PR_SIZE]] = 1'b0;
        for (int a = 0; a < NUM_ALLOC; a++)
            if (w_al_ok[a]) w_busy_nxt[alloc_addr[a*PR_SIZE +: PR_SIZE]] = 1'b1;
        if (flush) w_busy_nxt = '0;
        w_busy_nxt[0] = 1'b0;
    end

    always_comb begin
        w_collide = 1'b0;
        for (int i = 0; i < NUM_WR; i++)
            for (int j = i + 1; j < NUM_WR; j++)
                if (wr_en[i] && wr_en[j] &&
                    (wr_addr[i*PR_SIZE +: PR_SIZE] == wr_addr[j*PR_SIZE +: PR_SIZE]) &&
                    (wr_addr[i*PR_SIZE +: PR_SIZE] != '0))
                    w_collide = 1'b1;
    end

    // Write-first bypass: later (higher-index) write ports override earlier ones.
    always_comb begin
        for (int r = 0; r < NUM_RD; r++) begin
            w_rd_data[r]  = '0;
            w_rd_ready[r] = 1'b1;
            if (addr_ok(rd_addr[r*PR_SIZE +: PR_SIZE])) begin
                w_rd_data[r]  = r_mem[rd_addr[r*PR_SIZE +: PR_SIZE]];
                w_rd_ready[r] = ~w_busy_nxt[rd_addr[r*PR_SIZE +: PR_SIZE]];
                for (int w = 0; w < NUM_WR; w++)
                    if (w_wr_ok[w] &&
                        (wr_addr[w*PR_SIZE +: PR_SIZE] == rd_addr[r*PR_SIZE +: PR_SIZE]))
                        w_rd_data[r] = wr_data[w*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < PR_ARRAY; i++) r_mem[i] <= '0;
            r_busy     <= '0;
            rd_data    <= '0;
            rd_ready   <= '1;
            wr_collide <= 1'b0;
        end else begin
            for (int w = 0; w < NUM_WR; w++)
                if (w_wr_ok[w]) r_mem[wr_addr[w*PR_SIZE +: PR_SIZE]] <= wr_data[w*DATA_W +: DATA_W];
            r_busy     <= w_busy_nxt;
            wr_collide <= w_collide;
            for (int r = 0; r < NUM_RD; r++) begin
                if (rd_en[r]) begin
                    rd_data[r*DATA_W +: DATA_W] <= w_rd_data[r];
                    rd_ready[r]                 <= w_rd_ready[r];
                end
            end
        end
    end

endmodule

`default_nettype wire
